// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Front end between the raw chip pins and the Turing machine core. Each raw
//   input passes through a 2-flop synchronizer. The Next and Done buttons are
//   then debounced into stable levels and one-cycle press strobes. The data
//   switches are captured on every accepted Next strobe, so the core sees a
//   stable symbol alongside each step strobe.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     When this macro is defined, holding Next produces extra next_pulse
//     strobes. The first repeat comes REPEAT_DELAY cycles after the initial
//     pulse, and later repeats come every REPEAT_CYCLES cycles. When the macro
//     is undefined, the repeat timer is not built.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   data_raw    in   asynchronous data switches [DATA_WIDTH]
//   next_raw    in   asynchronous Next button, 1 = pressed
//   done_raw    in   asynchronous Done button, 1 = pressed
//   data_out    out  data captured at the last accepted Next pulse
//   next_pulse  out  one-cycle strobe per accepted Next press
//   done_pulse  out  one-cycle strobe per accepted Done press
//   next_level  out  debounced Next level
//   done_level  out  debounced Done level
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// input_conditioner_debounce
//   Debounces one synchronized button sample. The debounced level changes only
//   after DEBOUNCE_CYCLES consecutive samples disagree with the current level.
//   The rise output is a combinational flag. It is high on the cycle whose
//   closing edge moves the FSM into PRESSED.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   RELEASED | debounced level 0, counting samples of 1
//   PRESSED  | debounced level 1, counting samples of 0
//
// Ports
//   clock  in   system clock
//   reset  in   synchronous, active-high reset
//   s      in   synchronized button sample
//   level  out  debounced level
//   rise   out  high when the level toggles 0 -> 1 at the next edge
// -----------------------------------------------------------------------------
module input_conditioner_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic s,
  output logic level,
  output logic rise
);

  typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Toggling on cnt == D-1 means the D-th disagreeing sample is the one that
  // moves the level. Because of that, cnt never holds a value of D or more.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    rise      = 1'b0;
    if (s != (state == PRESSED)) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        if (state == RELEASED) begin
          state_nxt = PRESSED;
          rise      = 1'b1;
        end else begin
          state_nxt = RELEASED;
        end
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  assign level = (state == PRESSED);

endmodule

module input_conditioner #(
  parameter int DATA_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_CYCLES   = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_raw,
  input  logic                  next_raw,
  input  logic                  done_raw,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  next_pulse,
  output logic                  done_pulse,
  output logic                  next_level,
  output logic                  done_level
);

  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_DR > REPEAT_CYCLES) ? MAX_DR : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);
  localparam int SYNC_W  = DATA_WIDTH + 2;

  logic [SYNC_W-1:0]     sync1, sync2;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  next_s, done_s;
  logic                  next_rise, done_rise;
  logic                  next_fire;

  // The data, Next and Done inputs all go through one synchronizer bank.
  // Reset clears it, so a button held through reset is seen as a fresh press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {done_raw, next_raw, data_raw};
      sync2 <= sync1;
    end
  end

  assign data_s = sync2[DATA_WIDTH-1:0];
  assign next_s = sync2[DATA_WIDTH];
  assign done_s = sync2[DATA_WIDTH+1];

  input_conditioner_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_next (
    .clock (clock),
    .reset (reset),
    .s     (next_s),
    .level (next_level),
    .rise  (next_rise)
  );

  input_conditioner_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_done (
    .clock (clock),
    .reset (reset),
    .s     (done_s),
    .level (done_level),
    .rise  (done_rise)
  );

`ifdef AUTO_REPEAT_EN
  // The repeat timer is a down-counter. It is loaded on the press edge and
  // fires at terminal count. While the button is released it rests at 0, and
  // the next_level term in rpt_fire keeps it quiet in that state.
  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_fire;

  assign rpt_fire = next_level && (rpt_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else if (next_rise) begin
      rpt_cnt <= CNT_W'(REPEAT_DELAY - 1);
    end else if (!next_level) begin
      rpt_cnt <= '0;
    end else if (rpt_fire) begin
      rpt_cnt <= CNT_W'(REPEAT_CYCLES - 1);
    end else begin
      rpt_cnt <= rpt_cnt - CNT_W'(1);
    end
  end

  assign next_fire = next_rise | rpt_fire;
`else
  assign next_fire = next_rise;
`endif

  // If Done is accepted on the same edge as Next, Done wins. The Next strobe
  // is dropped, not deferred, and data_out keeps its previous value.
  always_ff @(posedge clock) begin
    if (reset) begin
      next_pulse <= 1'b0;
      done_pulse <= 1'b0;
      data_out   <= '0;
    end else begin
      done_pulse <= done_rise;
      next_pulse <= next_fire && !done_rise;
      if (next_fire && !done_rise) begin
        data_out <= data_s;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int DW = 4;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RC = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_raw = '0;
  logic          next_raw = 1'b0;
  logic          done_raw = 1'b0;
  logic [DW-1:0] data_out;
  logic          next_pulse, done_pulse, next_level, done_level;

  input_conditioner #(
    .DATA_WIDTH      (DW),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_CYCLES   (RC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_raw   (data_raw),
    .next_raw   (next_raw),
    .done_raw   (done_raw),
    .data_out   (data_out),
    .next_pulse (next_pulse),
    .done_pulse (done_pulse),
    .next_level (next_level),
    .done_level (done_level)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t next_q[$];
  int   done_q[$];
  exp_t mon_e;
  int   mon_c;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Expected Next strobes for a press driven right after edge c0, released
  // right after edge c0+hold. The level rises at edge c0+D+2 and falls at
  // edge c0+hold+D+2.
  task automatic push_press(input int c0, input int hold, input logic [DW-1:0] d);
    exp_t e;
    int   r;
    e.cyc  = c0 + D + 2;
    e.data = d;
    next_q.push_back(e);
    r = e.cyc + RD;
`ifdef AUTO_REPEAT_EN
    while (r <= c0 + hold + D + 2) begin
      e.cyc = r;
      next_q.push_back(e);
      r += RC;
    end
`endif
  endtask

  always @(negedge clock) begin
    if (next_pulse) begin
      if (next_q.size() == 0) chk("next_pulse_unexpected", 1, 0);
      else begin
        mon_e = next_q.pop_front();
        chk("next_pulse_cycle", cyc, mon_e.cyc);
        chk("next_pulse_data", data_out, mon_e.data);
      end
    end
    if (done_pulse) begin
      if (done_q.size() == 0) chk("done_pulse_unexpected", 1, 0);
      else begin
        mon_c = done_q.pop_front();
        chk("done_pulse_cycle", cyc, mon_c);
      end
    end
  end

  initial begin
    // 1: button held through reset counts as a fresh press
    next_raw = 1'b1;
    data_raw = 4'hA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_next_pulse", next_pulse, 0);
      chk("rst_done_pulse", done_pulse, 0);
      chk("rst_next_level", next_level, 0);
      chk("rst_data_out", data_out, 0);
    end
    reset = 1'b0;
    push_press(cyc, 15, 4'hA);
    tick(5);
    chk("t1_level_before", next_level, 0);
    tick(5);
    chk("t1_level_held", next_level, 1);
    tick(5);
    next_raw = 1'b0;
    tick(12);
    chk("t1_level_released", next_level, 0);
    chk("t1_data_out", data_out, 4'hA);

    // 2: glitch shorter than D samples
    data_raw = 4'hF;
    next_raw = 1'b1;
    tick(3);
    next_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_level_glitch", next_level, 0);
    end
    chk("t2_data_out", data_out, 4'hA);

    // 3: two separate presses
    data_raw = 4'h3;
    next_raw = 1'b1;
    push_press(cyc, 40, 4'h3);
    tick(40);
    next_raw = 1'b0;
    tick(15);
    chk("t3_data_first", data_out, 4'h3);
    chk("t3_level_rel1", next_level, 0);
    data_raw = 4'h5;
    next_raw = 1'b1;
    push_press(cyc, 12, 4'h5);
    tick(12);
    next_raw = 1'b0;
    tick(15);
    chk("t3_data_second", data_out, 4'h5);

    // 4: simultaneous Next and Done press, Done wins
    data_raw = 4'h9;
    next_raw = 1'b1;
    done_raw = 1'b1;
    done_q.push_back(cyc + D + 2);
    tick(8);
    chk("t4_next_level", next_level, 1);
    chk("t4_done_level", done_level, 1);
    tick(4);
    next_raw = 1'b0;
    done_raw = 1'b0;
    tick(15);
    chk("t4_data_unchanged", data_out, 4'h5);
    chk("t4_done_level_rel", done_level, 0);

    // 5: reset in the middle of a debounce count
    data_raw = 4'h7;
    next_raw = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(2);
    chk("t5_rst_level", next_level, 0);
    chk("t5_rst_data", data_out, 0);
    reset = 1'b0;
    push_press(cyc, 12, 4'h7);
    tick(12);
    next_raw = 1'b0;
    tick(15);
    chk("t5_data_after", data_out, 4'h7);

`ifdef AUTO_REPEAT_EN
    // 6: long hold gives auto-repeat strobes
    data_raw = 4'hC;
    next_raw = 1'b1;
    push_press(cyc, 56, 4'hC);
    tick(56);
    next_raw = 1'b0;
    tick(20);
    chk("t6_data", data_out, 4'hC);
`endif

    tick(5);
    chk("next_q_drained", next_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
